// File: rtl/hazard_ctl.sv
// rtl/hazard_ctl.sv - decode-stage RAW hazard, branch squash and halt-drain control
// Three-entry writer scoreboard shifts every cycle; outputs are combinational.
module hazard_ctl #(
  parameter int CHECK_W      = 0,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_d,
  input  logic [2:0]  Rs_d,
  input  logic [2:0]  Rt_d,
  input  logic        useRs_d,
  input  logic        useRt_d,
  input  logic [2:0]  Rd_d,
  input  logic        RegWrite_d,
  input  logic        halt_d,
  input  logic        branch_taken_x,
  output logic        stall,
  output logic        nop_d,
  output logic        flush,
  output logic        halt_done,
  output logic [15:0] stall_cnt
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t        state;
  logic [CW-1:0] drain_cnt;
  logic          sbx_v, sbm_v, sbw_v;
  logic [2:0]    sbx_rd, sbm_rd, sbw_rd;

  logic chk_w;
  logic match_rs, match_rt;
  logic hazard, run, issue;

  assign chk_w = (CHECK_W != 0);

  assign match_rs = (sbx_v & (sbx_rd == Rs_d)) | (sbm_v & (sbm_rd == Rs_d)) |
                    (chk_w & sbw_v & (sbw_rd == Rs_d));
  assign match_rt = (sbx_v & (sbx_rd == Rt_d)) | (sbm_v & (sbm_rd == Rt_d)) |
                    (chk_w & sbw_v & (sbw_rd == Rt_d));

  assign hazard = valid_d & ((useRs_d & match_rs) | (useRt_d & match_rt));
  assign run    = (state == RUN);
  assign issue  = rst & run & valid_d & ~hazard & ~branch_taken_x;

  // Reset forces the quiescent output pattern regardless of decode inputs.
  always_comb begin
    stall = 1'b0;
    nop_d = 1'b1;
    flush = 1'b0;
    if (rst) begin
      if (run) begin
        stall = hazard & ~branch_taken_x;
        nop_d = ~issue;
        flush = branch_taken_x;
      end else begin
        stall = 1'b1;
        nop_d = 1'b1;
      end
    end
  end

  assign halt_done = rst & (state == HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      sbx_v     <= 1'b0;
      sbm_v     <= 1'b0;
      sbw_v     <= 1'b0;
      sbx_rd    <= '0;
      sbm_rd    <= '0;
      sbw_rd    <= '0;
      stall_cnt <= '0;
    end else begin
      sbw_v  <= sbm_v;
      sbw_rd <= sbm_rd;
      sbm_v  <= sbx_v;
      sbm_rd <= sbx_rd;
      sbx_v  <= issue & RegWrite_d;
      sbx_rd <= Rd_d;

      if (run && stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;

      case (state)
        RUN: begin
          if (issue && halt_d) begin
            state     <= DRAIN;
            drain_cnt <= CW'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= HALTED;
          else                 drain_cnt <= drain_cnt - CW'(1);
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule
